// File: rtl/pipe_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
//   Shared types and helpers for the pipe scheduler of the LED-matrix bird
//   game.
//   - game_state_t : IDLE / RUN / OVER game phases
//   - ROWS         : default rows per column (width of the 'next' column)
//   - SCORE_W      : score width (saturating 8-bit counter)
//   - LFSR_TAPS    : Galois feedback mask of the gap generator
//   - lfsr_step()  : one Galois LFSR advance
//   - gap_base()   : lowest open row of a pipe, given three random bits
// ----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } game_state_t;

    localparam int         ROWS      = 8;
    localparam int         SCORE_W   = 8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Right-shifting Galois form: the bit falling out of the bottom folds
    // back through the tap mask. A non-zero state never becomes zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // Three random bits give 0..7; values that would push the gap past the
    // top row are folded back down so the gap always fits in the column.
    function automatic int gap_base(input logic [2:0] g, input int rows,
                                    input int gap_height);
        int base;
        base = int'(g);
        if (base > rows - gap_height) begin
            base = base - (rows - gap_height + 1);
        end
        return base;
    endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// ----------------------------------------------------------------------------
// pipe_scheduler_if
//   Game-control bundle between the pipe scheduler and the rest of the game
//   (input debouncer, collision detector, column shifters).
//   start       : one-cycle debounced pulse, begins a game or clears OVER
//   collide     : bird overlaps a lit pipe pixel (level)
//   ongoing     : game active; shifters clear while low
//   gameOver    : freeze request to the shifters
//   scroll_tick : one-cycle strobe, a column is committed to 'next'
//   next        : incoming rightmost column, 1 = lit pipe pixel
//   score       : pipes passed, saturating
//   modport master : the scheduler
//   modport slave  : the game environment around it
// ----------------------------------------------------------------------------
interface pipe_scheduler_if #(
    parameter int ROWS = game_pkg::ROWS
) ();
    import game_pkg::*;

    logic               start;
    logic               collide;
    logic               ongoing;
    logic               gameOver;
    logic               scroll_tick;
    logic [ROWS-1:0]    next;
    logic [SCORE_W-1:0] score;

    modport master (
        input  start, collide,
        output ongoing, gameOver, scroll_tick, next, score
    );

    modport slave (
        output start, collide,
        input  ongoing, gameOver, scroll_tick, next, score
    );

endinterface

// File: rtl/pipe_scheduler_lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8
//   8-bit Galois LFSR (taps 8'hB8) that advances on every clock in every game
//   state, so the moment the player presses start decides the gap sequence.
//   clk   in  1  clock
//   reset in  1  synchronous, active-high; loads seed
//   seed  in  8  non-zero reset value
//   q     out 8  current LFSR state
// ----------------------------------------------------------------------------
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// ----------------------------------------------------------------------------
// pipe_scheduler
//   Game-level sequencer for the scrolling pipe datapath. Runs the
//   IDLE/RUN/OVER game FSM, paces the scroll with a TICK_DIV divider, emits
//   the rightmost column (a pipe with a pseudo-random gap every PIPE_SPACING
//   steps, blank otherwise) and scores each pipe once it has travelled
//   BIRD_LAG steps to the bird column.
//   clk    in   1           clock
//   reset  in   1           synchronous, active-high
//   bus    master modport   start/collide in; ongoing, gameOver,
//                           scroll_tick, next, score out
//   All outputs are registered except scroll_tick, which is decoded from
//   the state, the tick counter and collide.
// ----------------------------------------------------------------------------
module pipe_scheduler
    import game_pkg::*;
#(
    parameter int         ROWS         = game_pkg::ROWS,
    parameter int         TICK_DIV     = 256,
    parameter int         PIPE_SPACING = 4,
    parameter int         GAP_HEIGHT   = 3,
    parameter int         BIRD_LAG     = 7,
    parameter logic [7:0] LFSR_SEED    = 8'hB8
) (
    input  logic             clk,
    input  logic             reset,
    pipe_scheduler_if.master bus
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int COL_W  = $clog2(PIPE_SPACING);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PIPE_SPACING - 1);

    game_state_t        state_q;
    game_state_t        state_d;
    logic               ongoing_q;
    logic               game_over_q;
    logic               scroll_tick;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [COL_W-1:0]   col_cnt_q;
    logic [BIRD_LAG-1:0] lag_q;
    logic [ROWS-1:0]    next_q;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         lfsr_q;
    logic [ROWS-1:0]    pipe_col;
    logic               pipe_now;
    int                 base;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Pipe column for the current LFSR value: all rows lit except a
    // GAP_HEIGHT-tall opening starting at 'base'.
    always_comb begin
        pipe_col = '1;
        base     = gap_base(lfsr_q[2:0], ROWS, GAP_HEIGHT);
        for (int r = 0; r < ROWS; r++) begin
            if (r >= base && r < base + GAP_HEIGHT) begin
                pipe_col[r] = 1'b0;
            end
        end
    end

    assign pipe_now = (col_cnt_q == '0);

    // Next-state and scroll strobe. collide beats a same-cycle tick, so the
    // column under the bird is never shifted away on the losing step.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        scroll_tick = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.collide) begin
                    state_d = OVER;
                end else if (tick_cnt_q == TICK_LAST) begin
                    scroll_tick = 1'b1;
                end
            end
            OVER: begin
                if (bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ongoing_q   <= 1'b0;
            game_over_q <= 1'b0;
            tick_cnt_q  <= '0;
            col_cnt_q   <= '0;
            lag_q       <= '0;
            next_q      <= '0;
            score_q     <= '0;
        end else begin
            state_q <= state_d;
            // OVER keeps ongoing high so the shifters freeze instead of clearing.
            ongoing_q   <= (state_d != IDLE);
            game_over_q <= (state_d == OVER);

            unique case (state_q)
                RUN: begin
                    if (!bus.collide) begin
                        tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0
                                                                : tick_cnt_q + 1'b1;
                        if (scroll_tick) begin
                            // Loaded on the tick so it is stable when the
                            // shifter samples at its count==0.
                            next_q    <= pipe_now ? pipe_col : '0;
                            col_cnt_q <= (col_cnt_q == COL_LAST) ? '0
                                                                 : col_cnt_q + 1'b1;
                            // A pipe flag leaving the top of the lag line has
                            // just reached the bird column.
                            lag_q <= (lag_q << 1) | BIRD_LAG'(pipe_now);
                            if (lag_q[BIRD_LAG-1] && score_q != '1) begin
                                score_q <= score_q + 1'b1;
                            end
                        end
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        tick_cnt_q <= '0;
                        col_cnt_q  <= '0;
                        lag_q      <= '0;
                        next_q     <= '0;
                        score_q    <= '0;
                    end
                end
                default: begin
                    // IDLE parks everything at its reset value so RUN
                    // always starts from a clean divider and column phase.
                    tick_cnt_q <= '0;
                    col_cnt_q  <= '0;
                    lag_q      <= '0;
                    next_q     <= '0;
                    score_q    <= '0;
                end
            endcase
        end
    end

    assign bus.ongoing     = ongoing_q;
    assign bus.gameOver    = game_over_q;
    assign bus.scroll_tick = scroll_tick;
    assign bus.next        = next_q;
    assign bus.score       = score_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// ----------------------------------------------------------------------------
// tb_pipe_scheduler
//   Self-checking bench for pipe_scheduler with TICK_DIV=4, PIPE_SPACING=4,
//   BIRD_LAG=3. The reference model tracks the game phase, the number of RUN
//   cycles and the number of scroll ticks; the expected column and score are
//   derived arithmetically from the tick number.
// ----------------------------------------------------------------------------
module tb_pipe_scheduler;
    import game_pkg::*;

    localparam int NR  = 8;
    localparam int TD  = 4;
    localparam int PS  = 4;
    localparam int GH  = 3;
    localparam int LAG = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_scheduler_if #(.ROWS(NR)) bus ();

    pipe_scheduler #(
        .ROWS         (NR),
        .TICK_DIV     (TD),
        .PIPE_SPACING (PS),
        .GAP_HEIGHT   (GH),
        .BIRD_LAG     (LAG),
        .LFSR_SEED    (8'hB8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: phase 0=idle 1=run 2=over.
    int         m_phase = 0;
    int         m_k     = 0;
    int         m_ticks = 0;
    int         m_score = 0;
    logic [7:0] m_next  = 8'h00;
    logic [7:0] m_lfsr  = 8'hB8;

    int   total = 0;
    int   bad   = 0;
    logic obs_tick;
    logic mdl_tick;

    function automatic logic [7:0] ref_adv(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic logic [7:0] ref_adv4(input logic [7:0] v);
        return ref_adv(ref_adv(ref_adv(ref_adv(v))));
    endfunction

    function automatic logic [7:0] ref_pattern(input logic [7:0] l);
        logic [7:0] p;
        int         g;
        g = int'(l[2:0]);
        if (g > NR - GH) g = g - (NR - GH + 1);
        p = 8'hFF;
        for (int r = g; r < g + GH; r++) p[r] = 1'b0;
        return p;
    endfunction

    // {ongoing, gameOver, next, score}
    function automatic logic [17:0] exp_vec();
        return {m_phase != 0, m_phase == 2, m_next, 8'(m_score)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.ongoing, bus.gameOver, bus.next, bus.score};
    endfunction

    // One clock: drive inputs just after a falling edge, sample the
    // combinational strobe, advance the model on the rising edge and return
    // at the next falling edge where the registered outputs are settled.
    task automatic step(input logic s, input logic c, input logic r);
        logic [7:0] l_old;
        bus.start   = s;
        bus.collide = c;
        reset       = r;
        #1;
        obs_tick = bus.scroll_tick;
        mdl_tick = (m_phase == 1) && (m_k % TD == TD - 1) && !c;
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_k = 0; m_ticks = 0; m_score = 0;
            m_next  = 8'h00;
            m_lfsr  = 8'hB8;
        end else begin
            l_old  = m_lfsr;
            m_lfsr = ref_adv(m_lfsr);
            case (m_phase)
                0: if (s) begin
                    m_phase = 1; m_k = 0; m_ticks = 0;
                end
                1: if (c) begin
                    m_phase = 2;
                end else begin
                    if (m_k % TD == TD - 1) begin
                        m_ticks++;
                        m_next = ((m_ticks - 1) % PS == 0) ? ref_pattern(l_old) : 8'h00;
                        if (m_ticks > LAG && (m_ticks - LAG - 1) % PS == 0 && m_score < 255)
                            m_score++;
                    end
                    m_k++;
                end
                default: if (s) begin
                    m_phase = 0; m_next = 8'h00; m_score = 0;
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (dut_vec() !== 18'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec(), 18'h0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (obs_tick !== 1'b0) begin
                bad++;
                $display("FAIL idle_tick cyc %0d: got %b want 0", i, obs_tick);
            end
            total++;
            if (dut_vec() !== 18'h0) begin
                bad++;
                $display("FAIL idle_outputs cyc %0d: got %h want %h", i, dut_vec(), 18'h0);
            end
        end
    endtask

    task automatic test_run();
        logic ok;
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (bus.ongoing !== 1'b1 || bus.gameOver !== 1'b0) begin
            bad++;
            $display("FAIL run_entry: got ongoing=%b gameOver=%b want 1 0",
                     bus.ongoing, bus.gameOver);
        end
        for (int cyc = 0; cyc < 21; cyc++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (obs_tick !== (cyc % 4 == 3)) begin
                bad++;
                $display("FAIL run_tick cyc %0d: got %b want %b", cyc, obs_tick, cyc % 4 == 3);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL run_outputs cyc %0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
            if (cyc == 3 || cyc == 19) begin
                ok = 1'b0;
                for (int b = 0; b <= NR - GH; b++) begin
                    if (bus.next === ~(8'h07 << b)) ok = 1'b1;
                end
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL pipe_shape cyc %0d: got %b want 3 contiguous zeros",
                             cyc, bus.next);
                end
            end
        end
    endtask

    task automatic test_pattern(input logic [7:0] target, input logic [7:0] want);
        bit found;
        step(1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (ref_adv4(m_lfsr) == target) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL pattern_seek %h: lfsr value not reached", target);
        end
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.next !== want) begin
            bad++;
            $display("FAIL pattern_%h: got %b want %b", target, bus.next, want);
        end
    endtask

    task automatic test_score();
        int want;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 12; t++) begin
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
            want = int'(t >= 4) + int'(t >= 8) + int'(t >= 12);
            total++;
            if (bus.score !== 8'(want)) begin
                bad++;
                $display("FAIL score_tick %0d: got %0d want %0d", t, bus.score, want);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL score_outputs tick %0d: got %h want %h", t, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_collide();
        logic [7:0] held_next;
        logic [7:0] held_score;
        for (int i = 0; i < 8 && (m_k % TD != TD - 1); i++) step(1'b0, 1'b0, 1'b0);
        held_next  = m_next;
        held_score = 8'(m_score);
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (obs_tick !== 1'b0) begin
            bad++;
            $display("FAIL collide_tick: got %b want 0", obs_tick);
        end
        total++;
        if (dut_vec() !== {1'b1, 1'b1, held_next, held_score}) begin
            bad++;
            $display("FAIL collide_over: got %h want %h", dut_vec(),
                     {1'b1, 1'b1, held_next, held_score});
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            total++;
            if (obs_tick !== 1'b0 || dut_vec() !== {1'b1, 1'b1, held_next, held_score}) begin
                bad++;
                $display("FAIL over_hold cyc %0d: got tick=%b out=%h want tick=0 out=%h",
                         i, obs_tick, dut_vec(), {1'b1, 1'b1, held_next, held_score});
            end
        end
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== 18'h0) begin
            bad++;
            $display("FAIL over_to_idle: got %h want %h", dut_vec(), 18'h0);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        total++;
        if (dut_vec() !== 18'h0) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", dut_vec(), 18'h0);
        end
        step(1'b1, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (obs_tick !== (cyc == 3)) begin
                bad++;
                $display("FAIL restart_tick cyc %0d: got %b want %b", cyc, obs_tick, cyc == 3);
            end
        end
    endtask

    task automatic test_random();
        logic s, c, r;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(0, 24) == 0);
            c = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 499) == 0);
            step(s, c, r);
            total++;
            if (obs_tick !== mdl_tick) begin
                bad++;
                $display("FAIL random_tick cyc %0d: got %b want %b", i, obs_tick, mdl_tick);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_outputs cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4400; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (obs_tick !== mdl_tick || dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL long_run cyc %0d: got tick=%b out=%h want tick=%b out=%h",
                         i, obs_tick, dut_vec(), mdl_tick, exp_vec());
            end
        end
        total++;
        if (bus.score !== 8'd255) begin
            bad++;
            $display("FAIL score_saturate: got %0d want 255", bus.score);
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.collide = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        test_reset();
        test_run();
        test_pattern(8'h07, 8'b11110001);
        test_pattern(8'h05, 8'b00011111);
        test_score();
        test_collide();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
